// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared BIST constants, state encoding and MISR step function
//
// Purpose : definitions shared by the signature analyzer, its MISR register
//           and the BIST controller (session length is derived from the
//           controller's loop bounds N and M).
// Ports   : none (package).
package bist_pkg;

   localparam int         DEF_WIDTH  = 8;
   localparam logic [7:0] DEF_POLY   = 8'h1D;
   localparam logic [7:0] DEF_SEED   = 8'h00;
   localparam logic [7:0] DEF_GOLDEN = 8'h00;
   localparam int         DEF_CNT_W  = 8;

   // Controller loop bounds; one RUNNING cycle per (n,m) pair minus the
   // final pair that the controller spends issuing FINISH.
   localparam int BIST_N      = 6;
   localparam int BIST_M      = 12;
   localparam int EXP_VECTORS = (BIST_N + 1) * (BIST_M + 1) - 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      COMPACT = 2'd2,
      DONE    = 2'd3
   } bist_state_t;

   // One Galois MISR step on a value of 'width' bits held in the low end of
   // a 32-bit word: shift left, fold the dropped MSB back through the taps,
   // then XOR in the response vector.
   function automatic logic [31:0] misr_step(input logic [31:0] q,
                                             input logic [31:0] d,
                                             input logic [31:0] poly,
                                             input int          width);
      logic [31:0] mask;
      logic [31:0] shifted;
      mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      shifted = (q << 1) & mask;
      if (q[width-1]) begin
         shifted = shifted ^ poly;
      end
      return (shifted ^ d) & mask;
   endfunction

endpackage

// File: rtl/bist_signature_analyzer_misr_reg.sv
// rtl/bist_signature_analyzer_misr_reg.sv - loadable Galois MISR register
//
// Purpose : holds the response signature; LOAD reseeds, EN compacts i_d.
// Ports   : i_clk      rising-edge clock
//           i_reset_n  asynchronous active-low reset (Q <= SEED)
//           i_load     load SEED (priority over i_en)
//           i_en       compact i_d into the signature this cycle
//           i_d        response vector, WIDTH bits
//           o_q        current signature, WIDTH bits (registered)
module misr_reg
   import bist_pkg::*;
#(
   parameter int               WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_step;

   assign w_step = WIDTH'(misr_step(32'(r_q), 32'(i_d), 32'(POLY), WIDTH));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_q <= SEED;
      end else if (i_load) begin
         r_q <= SEED;
      end else if (i_en) begin
         r_q <= w_step;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/bist_signature_analyzer.sv
// rtl/bist_signature_analyzer.sv - BIST response compactor and pass/fail evaluator
//
// Purpose : compacts CUT responses into a MISR signature under the BIST
//           controller's INIT/RUNNING/FINISH strobes, counts vectors and
//           latches PASS/FAIL against golden values on FINISH.
// Ports   : i_clk        rising-edge clock
//           i_reset_n    asynchronous active-low reset
//           i_init       1-cycle strobe, start a session (highest priority)
//           i_running    level, compact i_cut_out this cycle
//           i_finish     1-cycle strobe, end session and evaluate
//           i_cut_out    CUT response vector, WIDTH bits
//           o_signature  current MISR contents
//           o_vec_count  RUNNING cycles since INIT, saturating
//           o_done       result valid, held until next INIT
//           o_pass       signature and count both matched
//           o_fail       result valid and not pass
//           o_proto_err  sticky protocol violation, cleared by INIT/reset
module bist_signature_analyzer
   import bist_pkg::*;
#(
   parameter int               WIDTH       = DEF_WIDTH,
   parameter logic [WIDTH-1:0] POLY        = WIDTH'(DEF_POLY),
   parameter logic [WIDTH-1:0] SEED        = WIDTH'(DEF_SEED),
   parameter logic [WIDTH-1:0] GOLDEN      = WIDTH'(DEF_GOLDEN),
   parameter int               EXP_VECTORS = bist_pkg::EXP_VECTORS,
   parameter int               CNT_W       = DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_init,
   input  logic             i_running,
   input  logic             i_finish,
   input  logic [WIDTH-1:0] i_cut_out,
   output logic [WIDTH-1:0] o_signature,
   output logic [CNT_W-1:0] o_vec_count,
   output logic             o_done,
   output logic             o_pass,
   output logic             o_fail,
   output logic             o_proto_err
);

   bist_state_t r_state;
   bist_state_t w_state_nxt;

   logic [CNT_W-1:0] r_vec_count;
   logic             r_done;
   logic             r_pass;
   logic             r_fail;
   logic             r_proto_err;

   logic             w_load;
   logic             w_en;
   logic             w_cnt_clr;
   logic             w_cnt_inc;
   logic             w_eval;
   logic             w_clr_flags;
   logic             w_proto_set;

   logic [WIDTH-1:0] w_sig;
   logic [WIDTH-1:0] w_sig_upd;
   logic [CNT_W-1:0] w_cnt_upd;
   logic             w_match;

   misr_reg #(
      .WIDTH (WIDTH),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_load    (w_load),
      .i_en      (w_en),
      .i_d       (i_cut_out),
      .o_q       (w_sig)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_en        = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_eval      = 1'b0;
      w_clr_flags = 1'b0;
      w_proto_set = 1'b0;

      if (i_init) begin
         // Restart always wins; RUNNING/FINISH in the same cycle are dropped.
         w_state_nxt = ARMED;
         w_load      = 1'b1;
         w_cnt_clr   = 1'b1;
         w_clr_flags = 1'b1;
         // Re-initialising while vectors are still streaming aborts a session.
         w_proto_set = (r_state == COMPACT) && i_running;
      end else begin
         case (r_state)
            IDLE: begin
               w_proto_set = i_running || i_finish;
            end
            ARMED, COMPACT: begin
               if (i_running) begin
                  w_en        = 1'b1;
                  w_cnt_inc   = 1'b1;
                  w_state_nxt = COMPACT;
               end
               if (i_finish) begin
                  w_eval      = 1'b1;
                  w_state_nxt = DONE;
               end
            end
            DONE: begin
               w_proto_set = i_finish;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // The verdict must see a RUNNING vector that arrives together with
   // FINISH, so compare against the post-update signature and count.
   assign w_sig_upd = w_en
                    ? WIDTH'(misr_step(32'(w_sig), 32'(i_cut_out), 32'(POLY), WIDTH))
                    : w_sig;
   assign w_cnt_upd = (w_cnt_inc && (r_vec_count != {CNT_W{1'b1}}))
                    ? r_vec_count + 1'b1
                    : r_vec_count;
   assign w_match   = (w_sig_upd == GOLDEN) && (w_cnt_upd == CNT_W'(EXP_VECTORS));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_vec_count <= '0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail      <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_vec_count <= w_cnt_clr ? '0 : w_cnt_upd;

         if (w_clr_flags) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_fail <= 1'b0;
         end else if (w_eval) begin
            r_done <= 1'b1;
            r_pass <= w_match;
            r_fail <= !w_match;
         end

         // An aborting INIT both clears and re-flags; the flag must survive.
         if (w_proto_set) begin
            r_proto_err <= 1'b1;
         end else if (w_clr_flags) begin
            r_proto_err <= 1'b0;
         end
      end
   end

   assign o_signature = w_sig;
   assign o_vec_count = r_vec_count;
   assign o_done      = r_done;
   assign o_pass      = r_pass;
   assign o_fail      = r_fail;
   assign o_proto_err = r_proto_err;

endmodule
